// File: rtl/bullet_slot_arbiter.sv
// Shared bullet slot pool for two tanks: fire-key edge decode, cooldown and
// per-tank cap gating, round-robin grant, and lifetime/kill retirement.
module bullet_slot_arbiter #(
  parameter int         NUM_SLOTS    = 4,
  parameter int         MAX_PER_TANK = 3,
  parameter int         LIFETIME     = 300,
  parameter int         COOLDOWN     = 15,
  parameter logic [7:0] KEY_FIRE1    = 8'h2C,
  parameter logic [7:0] KEY_FIRE2    = 8'h28
) (
  input  logic                 frame_clk,
  input  logic                 Reset_n,
  input  logic [31:0]          keycode,
  input  logic [9:0]           Tank1X,
  input  logic [9:0]           Tank1Y,
  input  logic [9:0]           Tank2X,
  input  logic [9:0]           Tank2Y,
  input  logic [4:0]           Angle1,
  input  logic [4:0]           Angle2,
  input  logic [NUM_SLOTS-1:0] kill,
  output logic [NUM_SLOTS-1:0] slot_active,
  output logic [NUM_SLOTS-1:0] slot_owner,
  output logic                 spawn_valid,
  output logic [2:0]           spawn_slot,
  output logic [9:0]           SpawnX,
  output logic [9:0]           SpawnY,
  output logic [4:0]           SpawnAngle
);

  localparam int          LIFE_W  = $clog2(LIFETIME + 1);
  localparam int          CD_W    = $clog2(COOLDOWN + 1);
  localparam int          CNT_W   = $clog2(NUM_SLOTS + 1);
  localparam logic [31:0] MAX_CNT = MAX_PER_TANK;

  logic [LIFE_W-1:0] life [NUM_SLOTS];
  logic [CD_W-1:0]   cooldown [2];
  logic [1:0]        key_now, key_prev, key_rise;
  logic [1:0]        pending, cap_ok, cd_zero, req;
  logic [CNT_W-1:0]  count1, count2;
  logic              rr_pri;
  logic              free_found;
  logic [2:0]        free_idx;
  logic              grant_valid;
  logic              grant_tank;

  always_comb begin : key_decode
    key_now = 2'b00;
    for (int b = 0; b < 4; b++) begin
      if (keycode[8*b +: 8] == KEY_FIRE1) key_now[0] = 1'b1;
      if (keycode[8*b +: 8] == KEY_FIRE2) key_now[1] = 1'b1;
    end
  end

  assign key_rise = key_now & ~key_prev;

  always_comb begin : tank_counts
    count1 = '0;
    count2 = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (slot_active[s]) begin
        if (slot_owner[s]) count2 = count2 + CNT_W'(1);
        else               count1 = count1 + CNT_W'(1);
      end
    end
  end

  assign cap_ok[0]  = 32'(count1) < MAX_CNT;
  assign cap_ok[1]  = 32'(count2) < MAX_CNT;
  assign cd_zero[0] = (cooldown[0] == '0);
  assign cd_zero[1] = (cooldown[1] == '0);

  // Walking from the top down leaves the lowest free index as the winner.
  always_comb begin : slot_pick
    free_found = 1'b0;
    free_idx   = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (!slot_active[s]) begin
        free_found = 1'b1;
        free_idx   = 3'(s);
      end
    end
  end

  // A pending tank that has since hit its cap simply keeps waiting.
  always_comb begin : grant_arb
    req         = pending & cap_ok;
    grant_valid = 1'b0;
    grant_tank  = 1'b0;
    if (free_found) begin
      if (req == 2'b11) begin
        grant_valid = 1'b1;
        grant_tank  = rr_pri;
      end else if (req[0]) begin
        grant_valid = 1'b1;
        grant_tank  = 1'b0;
      end else if (req[1]) begin
        grant_valid = 1'b1;
        grant_tank  = 1'b1;
      end
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      key_prev    <= '0;
      pending     <= '0;
      cooldown[0] <= '0;
      cooldown[1] <= '0;
      rr_pri      <= 1'b0;
    end else begin
      key_prev <= key_now;
      if (grant_valid) rr_pri <= ~grant_tank;
      for (int t = 0; t < 2; t++) begin
        if (grant_valid && (grant_tank == 1'(t))) begin
          pending[t]  <= 1'b0;
          cooldown[t] <= CD_W'(COOLDOWN);
        end else begin
          if (key_rise[t] && cd_zero[t] && cap_ok[t]) pending[t] <= 1'b1;
          if (!cd_zero[t]) cooldown[t] <= cooldown[t] - CD_W'(1);
        end
      end
    end
  end

  // Granted slots are inactive at cycle start, so grant and retire never collide.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      slot_active <= '0;
      slot_owner  <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) life[s] <= '0;
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (grant_valid && (free_idx == 3'(s))) begin
          slot_active[s] <= 1'b1;
          slot_owner[s]  <= grant_tank;
          life[s]        <= LIFE_W'(LIFETIME);
        end else if (slot_active[s]) begin
          if ((life[s] == LIFE_W'(1)) || kill[s]) begin
            slot_active[s] <= 1'b0;
            life[s]        <= '0;
          end else begin
            life[s] <= life[s] - LIFE_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      spawn_valid <= 1'b0;
      spawn_slot  <= '0;
      SpawnX      <= '0;
      SpawnY      <= '0;
      SpawnAngle  <= '0;
    end else begin
      spawn_valid <= grant_valid;
      if (grant_valid) begin
        spawn_slot <= free_idx;
        SpawnX     <= grant_tank ? Tank2X : Tank1X;
        SpawnY     <= grant_tank ? Tank2Y : Tank1Y;
        SpawnAngle <= grant_tank ? Angle2 : Angle1;
      end
    end
  end

endmodule
